// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: issues one valid/ready imem read per PC and holds the result for decode.
// Latency: request in cycle t, response at t+1 or later, instruction valid one cycle after the response.
// Backpressure: request valid/address stay fixed until accepted; a held instruction waits for inst_ready_i.
module ysyx_22040237_ifu #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  output logic              pc_advance_o,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [ADDR_W-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [INST_W-1:0] imem_rsp_data_i,
  input  logic              imem_rsp_err_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_fault_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]        state_q,    state_d;
  logic              drop_q,     drop_d;      // response of the outstanding request must be discarded
  logic              first_q,    first_d;     // first cycle in REQ: address comes straight from pc_i
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [INST_W-1:0] inst_q,     inst_d;
  logic [ADDR_W-1:0] inst_pc_q,  inst_pc_d;
  logic              fault_q,    fault_d;

  logic misaligned;
  logic req_vld;

  // Request handshake and decode-side outputs derived from the current state
  always_comb begin
    misaligned       = (pc_i[1:0] != 2'b00);
    // A misaligned PC never reaches memory; it is reported as a fault instead
    req_vld          = (state_q == S_REQ) && !(first_q && misaligned);
    imem_req_valid_o = req_vld;
    imem_req_addr_o  = req_vld ? (first_q ? pc_i : req_addr_q) : '0;
    inst_valid_o     = (state_q == S_HOLD);
    pc_advance_o     = (state_q == S_HOLD) && inst_ready_i && !flush_i;
    inst_o           = inst_q;
    inst_pc_o        = inst_pc_q;
    inst_fault_o     = fault_q;
  end

  // Next-state logic; flush_i takes priority over any simultaneous event
  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    first_d    = first_q;
    req_addr_d = req_addr_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    fault_d    = fault_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        first_d = 1'b1;
      end
      S_REQ: begin
        if (first_q) req_addr_d = pc_i;
        if (first_q && misaligned) begin
          // On flush nothing was issued, so simply retry at the jump target
          if (!flush_i) begin
            inst_d    = '0;
            inst_pc_d = pc_i;
            fault_d   = 1'b1;
            state_d   = S_HOLD;
          end
        end else begin
          first_d = 1'b0;
          // A request once raised must complete; a flush only marks its response stale
          if (flush_i) drop_d = 1'b1;
          if (imem_req_ready_i) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          if (drop_q || flush_i) begin
            drop_d  = 1'b0;
            first_d = 1'b1;
            state_d = S_REQ;
          end else begin
            inst_d    = imem_rsp_err_i ? '0 : imem_rsp_data_i;
            inst_pc_d = req_addr_q;
            fault_d   = imem_rsp_err_i;
            state_d   = S_HOLD;
          end
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush_i || inst_ready_i) begin
          first_d = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      drop_q     <= 1'b0;
      first_q    <= 1'b0;
      req_addr_q <= '0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      first_q    <= first_d;
      req_addr_q <= req_addr_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      fault_q    <= fault_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Bench for the fetch unit: directed scenarios followed by randomized traffic
// checked against a PC-register / instruction-memory reference model.
module tb_ysyx_22040237_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc;
  logic        flush;
  logic        pc_advance_o;
  logic        imem_req_valid_o;
  logic        req_ready;
  logic [63:0] imem_req_addr_o;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        inst_valid_o;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic        inst_fault_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22040237_ifu #(.ADDR_W(64), .INST_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_i             (pc),
    .flush_i          (flush),
    .pc_advance_o     (pc_advance_o),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (req_ready),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .imem_rsp_err_i   (rsp_err),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .inst_fault_o     (inst_fault_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Instruction memory contents and error map
  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5_0013;
  endfunction
  function automatic logic mem_err(input logic [63:0] a);
    return a[6:2] == 5'h1F;
  endfunction
  function automatic logic exp_fault(input logic [63:0] p);
    return (p[1:0] != 2'b00) || mem_err(p);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ival"}, inst_valid_o, 1'b0);
    chk({tag, "_rval"}, imem_req_valid_o, 1'b0);
    chk({tag, "_raddr"}, imem_req_addr_o, 64'h0);
    chk({tag, "_adv"}, pc_advance_o, 1'b0);
    chk({tag, "_inst"}, inst_o, 32'h0);
    chk({tag, "_ipc"}, inst_pc_o, 64'h0);
    chk({tag, "_flt"}, inst_fault_o, 1'b0);
  endtask

  logic [63:0] model_pc, target, rsp_addr, prev_addr, ra;
  logic        pending, prev_stall, adv, rv;
  int          cnt, advances;

  initial begin
    rst = 1'b1; pc = 64'h8000_0000; req_ready = 1'b1; rsp_valid = 1'b0;
    rsp_data = '0; rsp_err = 1'b0; inst_ready = 1'b1; flush = 1'b0;
    tick(); tick();
    #1 chk_all_zero("reset");

    // Best-case fetch: request cycle 1, response cycle 2, instruction cycle 3
    rst = 1'b0;
    #1 chk("t1_idle_rval", imem_req_valid_o, 1'b0);
    tick();
    #1 chk("t1_c1_rval", imem_req_valid_o, 1'b1);
    chk("t1_c1_raddr", imem_req_addr_o, 64'h8000_0000);
    tick();
    rsp_valid = 1'b1; rsp_data = 32'h0000_0013;
    #1 chk("t1_c2_rval", imem_req_valid_o, 1'b0);
    chk("t1_c2_ival", inst_valid_o, 1'b0);
    tick();
    rsp_valid = 1'b0;
    #1 chk("t1_c3_ival", inst_valid_o, 1'b1);
    chk("t1_c3_inst", inst_o, 32'h0000_0013);
    chk("t1_c3_ipc", inst_pc_o, 64'h8000_0000);
    chk("t1_c3_flt", inst_fault_o, 1'b0);
    chk("t1_c3_adv", pc_advance_o, 1'b1);
    tick();
    pc = 64'h8000_0004;
    #1 chk("t1_c4_ival", inst_valid_o, 1'b0);
    chk("t1_c4_adv", pc_advance_o, 1'b0);
    chk("t1_c4_rval", imem_req_valid_o, 1'b1);
    chk("t1_c4_raddr", imem_req_addr_o, 64'h8000_0004);

    // Reset while waiting for a response
    tick();
    #1 chk("t6_wait_rval", imem_req_valid_o, 1'b0);
    rst = 1'b1;
    tick();
    #1 chk_all_zero("t6_rst");

    // Misaligned PC: no request, fault held for decode
    pc = 64'h8000_0002;
    tick();
    rst = 1'b0;
    #1 chk("t5_idle_rval", imem_req_valid_o, 1'b0);
    tick();
    inst_ready = 1'b0;
    #1 chk("t5_req_rval", imem_req_valid_o, 1'b0);
    tick();
    #1 chk("t5_ival", inst_valid_o, 1'b1);
    chk("t5_flt", inst_fault_o, 1'b1);
    chk("t5_inst", inst_o, 32'h0);
    chk("t5_ipc", inst_pc_o, 64'h8000_0002);

    // Decode stalls for 5 cycles: everything stays put
    for (int i = 0; i < 5; i++) begin
      tick();
      #1 chk("t3_ival", inst_valid_o, 1'b1);
      chk("t3_ipc", inst_pc_o, 64'h8000_0002);
      chk("t3_rval", imem_req_valid_o, 1'b0);
      chk("t3_adv", pc_advance_o, 1'b0);
    end

    // Flush and accept together in HOLD: no advance, refetch from target
    flush = 1'b1; inst_ready = 1'b1;
    #1 chk("t4_adv", pc_advance_o, 1'b0);
    tick();
    pc = 64'h8000_0100; flush = 1'b0;
    #1 chk("t4_ival", inst_valid_o, 1'b0);
    chk("t4_rval", imem_req_valid_o, 1'b1);
    chk("t4_raddr", imem_req_addr_o, 64'h8000_0100);

    // Memory error response
    tick();
    rsp_valid = 1'b1; rsp_err = 1'b1; rsp_data = 32'hDEAD_BEEF;
    #1 chk("t5e_rval", imem_req_valid_o, 1'b0);
    tick();
    rsp_valid = 1'b0; rsp_err = 1'b0; inst_ready = 1'b0;
    #1 chk("t5e_ival", inst_valid_o, 1'b1);
    chk("t5e_flt", inst_fault_o, 1'b1);
    chk("t5e_inst", inst_o, 32'h0);
    chk("t5e_ipc", inst_pc_o, 64'h8000_0100);
    inst_ready = 1'b1;
    #1 chk("t5e_adv", pc_advance_o, 1'b1);

    // Stalled request with a flush in its second cycle
    tick();
    pc = 64'h8000_0104; req_ready = 1'b0;
    #1 chk("t2_s1_rval", imem_req_valid_o, 1'b1);
    chk("t2_s1_raddr", imem_req_addr_o, 64'h8000_0104);
    tick();
    flush = 1'b1;
    #1 chk("t2_s2_raddr", imem_req_addr_o, 64'h8000_0104);
    tick();
    flush = 1'b0; pc = 64'h8000_0200;
    #1 chk("t2_s3_rval", imem_req_valid_o, 1'b1);
    chk("t2_s3_raddr", imem_req_addr_o, 64'h8000_0104);
    tick();
    req_ready = 1'b1;
    #1 chk("t2_s4_raddr", imem_req_addr_o, 64'h8000_0104);
    tick();
    rsp_valid = 1'b1; rsp_data = 32'h0000_1234;
    #1 chk("t2_wait_rval", imem_req_valid_o, 1'b0);
    tick();
    rsp_valid = 1'b0;
    #1 chk("t2_drop_ival", inst_valid_o, 1'b0);
    chk("t2_drop_adv", pc_advance_o, 1'b0);
    chk("t2_next_rval", imem_req_valid_o, 1'b1);
    chk("t2_next_raddr", imem_req_addr_o, 64'h8000_0200);

    // Randomized traffic against the PC / memory reference model
    rst = 1'b1; pc = 64'h8000_0000; flush = 1'b0; rsp_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    model_pc = 64'h8000_0000;
    pending = 1'b0; prev_stall = 1'b0; prev_addr = '0; rsp_addr = '0;
    cnt = 0; advances = 0;
    for (int c = 0; c < 3000; c++) begin
      req_ready  = ($urandom % 4) != 0;
      inst_ready = ($urandom % 4) != 0;
      flush      = ($urandom % 16) == 0;
      target     = 64'h8000_0000 + 64'($urandom_range(0, 1023) << 2)
                   + ((($urandom % 4) == 0) ? 64'd2 : 64'd0);
      rsp_valid  = pending && (cnt == 0);
      rsp_data   = rsp_valid ? mem_data(rsp_addr) : $urandom;
      rsp_err    = rsp_valid ? mem_err(rsp_addr) : 1'b0;
      pc         = model_pc;
      #1;
      chk("r_adv_rule", pc_advance_o, inst_valid_o && inst_ready && !flush);
      if (inst_valid_o) begin
        chk("r_ipc", inst_pc_o, model_pc);
        chk("r_flt", inst_fault_o, exp_fault(model_pc));
        chk("r_inst", inst_o, exp_fault(model_pc) ? 32'h0 : mem_data(model_pc));
      end
      if (prev_stall) begin
        chk("r_hold_rval", imem_req_valid_o, 1'b1);
        chk("r_hold_raddr", imem_req_addr_o, prev_addr);
      end else if (imem_req_valid_o) begin
        chk("r_new_raddr", imem_req_addr_o, model_pc);
      end
      if (pending) chk("r_one_outstanding", imem_req_valid_o, 1'b0);
      adv = pc_advance_o; rv = imem_req_valid_o; ra = imem_req_addr_o;
      @(posedge clk);
      if (flush) model_pc = target;
      else if (adv) begin
        model_pc = model_pc + 64'd4;
        advances++;
      end
      if (rsp_valid) pending = 1'b0;
      else if (pending) cnt--;
      if (rv && req_ready) begin
        pending  = 1'b1;
        cnt      = int'($urandom % 3);
        rsp_addr = ra;
      end
      prev_stall = rv && !req_ready;
      prev_addr  = ra;
      @(negedge clk);
    end
    chk("r_progress", 64'(advances >= 50), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
